// File: rtl/tdc_pkg.sv
// Shared definitions for the carry-chain TDC channel.
//   - FSM state encoding for the capture/handshake/dead-time sequence
//   - clog2 helper and fine-code width derivation
//   - default chain length and coarse counter width
package tdc_pkg;

  localparam int NCARRY4_DEF  = 50;
  localparam int COARSE_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DEAD    = 2'd3
  } tdc_state_t;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((32'd1 << width) < 32'(value)) width = width + 1;
    return width;
  endfunction

  // Fine code must represent 0..L inclusive, L = 4*ncarry4.
  function automatic int fine_width(input int ncarry4);
    return clog2(4 * ncarry4 + 1);
  endfunction

endpackage

// File: rtl/tdc_carry4_chain.sv
// Tapped delay line of NCARRY4 cascaded CARRY4 cells.
// CYINIT of the first cell is the hit input, CI is tied low, every
// select is 1 and every DI is 0, so the hit edge ripples along the
// carry outputs. Each carry output is one tap.
//   hit  : asynchronous hit input (CYINIT of cell 0)
//   taps : 4*NCARRY4 carry outputs, tap 0 nearest the hit entry
module tdc_carry4_chain #(
  parameter int NCARRY4 = 50
) (
  input  logic                 hit,
  output logic [4*NCARRY4-1:0] taps
);

  localparam logic [3:0] CELL_S  = 4'b1111;
  localparam logic [3:0] CELL_DI = 4'b0000;

  for (genvar i = 0; i < NCARRY4; i++) begin : g_cell
    logic                          ci;
    (* keep = "true" *) logic [3:0] co;
    logic                          c;

    if (i == 0) begin : g_first
      assign ci = hit | 1'b0;
    end else begin : g_next
      assign ci = g_cell[i-1].co[3];
    end

    // Carry-mux ripple through the four stages of one cell
    always_comb begin
      c  = ci;
      co = 4'b0000;
      for (int j = 0; j < 4; j++) begin
        c     = CELL_S[j] ? c : CELL_DI[j];
        co[j] = c;
      end
    end

    assign taps[4*i +: 4] = co;
  end

endmodule

// File: rtl/therm_popcount_enc.sv
// Bubble-tolerant thermometer encoder: counts the ones over all taps.
// Two-level adder tree (per-CARRY4 group counts, then a sum); purely
// combinational here. Registering a tree level adds one clock to the
// channel latency.
//   therm : L-bit sampled tap vector (L multiple of 4)
//   code  : number of '1' taps, 0..L
module therm_popcount_enc #(
  parameter int L      = 200,
  parameter int FINE_W = 8
) (
  input  logic [L-1:0]      therm,
  output logic [FINE_W-1:0] code
);

  localparam int NGRP = L / 4;

  logic [2:0]        grp_cnt [NGRP];
  logic [FINE_W-1:0] sum;

  // First tree level: ones within each 4-tap group
  always_comb begin
    grp_cnt = '{default: 3'd0};
    for (int g = 0; g < NGRP; g++) begin
      grp_cnt[g] = {2'b00, therm[4*g]}   + {2'b00, therm[4*g+1]} +
                   {2'b00, therm[4*g+2]} + {2'b00, therm[4*g+3]};
    end
  end

  // Second tree level: accumulate group counts
  always_comb begin
    sum = '0;
    for (int g = 0; g < NGRP; g++) begin
      sum = sum + FINE_W'(grp_cnt[g]);
    end
  end

  assign code = sum;

endmodule

// File: rtl/tdc_carry_chain_channel.sv
// Single-channel carry-chain TDC front end.
// The chain is sampled every clock (s1), re-registered (s2), a rising
// tap[0] marks the hit, and the fine code (popcount of s2) plus the
// coarse count at the sampling edge are held on a valid/ready output.
//   clk, rst_n : system clock, async active-low reset
//   hit        : asynchronous hit into the delay line
//   enable     : arms the channel; low aborts and clears miss_cnt
//   ts_valid/ts_ready : output handshake
//   ts_coarse, ts_fine, ts_sat : timestamp fields
//   miss_cnt   : saturating count of hits seen while busy
//   busy       : FSM not in IDLE
module tdc_carry_chain_channel
  import tdc_pkg::*;
#(
  parameter  int NCARRY4     = NCARRY4_DEF,
  parameter  int COARSE_W    = COARSE_W_DEF,
  parameter  int DEAD_CYCLES = 4,
  parameter  int MISS_W      = 8,
  localparam int L           = 4 * NCARRY4,
  localparam int FINE_W      = fine_width(NCARRY4)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hit,
  input  logic                enable,
  output logic                ts_valid,
  input  logic                ts_ready,
  output logic [COARSE_W-1:0] ts_coarse,
  output logic [FINE_W-1:0]   ts_fine,
  output logic                ts_sat,
  output logic [MISS_W-1:0]   miss_cnt,
  output logic                busy
);

  localparam int                  DCNT_W    = clog2(DEAD_CYCLES + 1);
  localparam logic [DCNT_W-1:0]   DEAD_LOAD = DCNT_W'(DEAD_CYCLES - 1);
  localparam logic [MISS_W-1:0]   MISS_MAX  = '1;
  localparam logic [FINE_W-1:0]   FULL_CODE = FINE_W'(L);

  (* keep = "true" *)     logic [L-1:0] taps;
  (* ASYNC_REG = "TRUE" *) logic [L-1:0] s1;
  (* ASYNC_REG = "TRUE" *) logic [L-1:0] s2;
  logic                prev0;
  logic                det;
  logic [FINE_W-1:0]   fine_code;
  logic [COARSE_W-1:0] coarse;
  logic [COARSE_W-1:0] coarse_d1;
  logic [COARSE_W-1:0] coarse_d2;
  tdc_state_t          state;
  logic [DCNT_W-1:0]   dead_cnt;

  tdc_carry4_chain #(
    .NCARRY4 (NCARRY4)
  ) u_chain (
    .hit  (hit),
    .taps (taps)
  );

  therm_popcount_enc #(
    .L      (L),
    .FINE_W (FINE_W)
  ) u_enc (
    .therm (s2),
    .code  (fine_code)
  );

  // Rising edge of the synchronised first tap
  assign det = s2[0] & ~prev0;

  // Tap sampling pipeline and coarse counter with matching two-deep delay,
  // so coarse_d2 lines up with s2 (the count at the s1 sampling edge)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      prev0     <= 1'b0;
      coarse    <= '0;
      coarse_d1 <= '0;
      coarse_d2 <= '0;
    end else begin
      s1        <= taps;
      s2        <= s1;
      prev0     <= s2[0];
      coarse    <= coarse + COARSE_W'(1);
      coarse_d1 <= coarse;
      coarse_d2 <= coarse_d1;
    end
  end

  // Capture / handshake / dead-time FSM with registered outputs.
  // The timestamp loads on the IDLE->CAPTURE edge so ts_valid appears two
  // clocks after the sampling edge; CAPTURE already honours ts_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ts_valid  <= 1'b0;
      ts_coarse <= '0;
      ts_fine   <= '0;
      ts_sat    <= 1'b0;
      miss_cnt  <= '0;
      busy      <= 1'b0;
      dead_cnt  <= '0;
    end else if (!enable) begin
      state    <= ST_IDLE;
      ts_valid <= 1'b0;
      miss_cnt <= '0;
      busy     <= 1'b0;
      dead_cnt <= '0;
    end else begin
      if (det && (state != ST_IDLE) && (miss_cnt != MISS_MAX)) begin
        miss_cnt <= miss_cnt + MISS_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (det) begin
            state     <= ST_CAPTURE;
            ts_valid  <= 1'b1;
            ts_coarse <= coarse_d2;
            ts_fine   <= fine_code;
            ts_sat    <= (fine_code == FULL_CODE);
            busy      <= 1'b1;
          end
        end
        ST_CAPTURE, ST_HOLD: begin
          if (ts_ready) begin
            state    <= ST_DEAD;
            ts_valid <= 1'b0;
            dead_cnt <= DEAD_LOAD;
          end else begin
            state <= ST_HOLD;
          end
        end
        ST_DEAD: begin
          if (dead_cnt != '0) begin
            dead_cnt <= dead_cnt - DCNT_W'(1);
          end else if (!s2[0]) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          ts_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_carry_chain_channel.sv
// Directed testbench for tdc_carry_chain_channel: a vector table of tap
// patterns (forced onto the chain output) with expected fine codes, plus
// hand-written sequences for backpressure, misses, abort, reset and wrap.
module tb_tdc_carry_chain_channel;
  import tdc_pkg::*;

  localparam int NC = 50;
  localparam int L  = 200;
  localparam int CW = 16;
  localparam int FW = 8;
  localparam int D  = 4;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hit;
  logic          enable;
  logic          ts_ready;
  logic          ts_valid;
  logic [CW-1:0] ts_coarse;
  logic [FW-1:0] ts_fine;
  logic          ts_sat;
  logic [MW-1:0] miss_cnt;
  logic          busy;

  always #5 clk = ~clk;

  tdc_carry_chain_channel #(
    .NCARRY4(NC), .COARSE_W(CW), .DEAD_CYCLES(D), .MISS_W(MW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hit(hit), .enable(enable),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_coarse(ts_coarse),
    .ts_fine(ts_fine), .ts_sat(ts_sat), .miss_cnt(miss_cnt), .busy(busy)
  );

  // Reference free-running count since reset release
  logic [15:0] tb_coarse;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_coarse <= 16'd0;
    else        tb_coarse <= tb_coarse + 16'd1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({ts_valid, ts_coarse, ts_fine, ts_sat, miss_cnt, busy});
  endfunction

  function automatic logic [63:0] ts_fields();
    return 64'({ts_valid, ts_coarse, ts_fine, ts_sat});
  endfunction

  function automatic logic [L-1:0] therm(input int n);
    logic [L-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic wait_coarse(input logic [15:0] t);
    int k;
    k = 0;
    while (tb_coarse !== t && k < 70000) begin
      @(negedge clk);
      k++;
    end
    if (tb_coarse !== t) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_coarse: timed out waiting for coarse 0x%0h", t);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: busy still 1 after %0d clocks", k);
    end
  endtask

  // One-clock hit pulse on the real input
  task automatic pulse_hit();
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [L-1:0] pat;
    logic [15:0]  at;
    logic [7:0]   fine;
    logic         sat;
  } vec_t;

  vec_t         vecs [6];
  logic [L-1:0] cur_pat;
  logic [15:0]  exp_c;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0].pat = therm(37);  vecs[0].at = 16'd100; vecs[0].fine = 8'd37;  vecs[0].sat = 1'b0;
    vecs[1].pat = '0;         vecs[1].pat[7:0] = 8'b1110_1101;
                              vecs[1].at = 16'd130; vecs[1].fine = 8'd6;   vecs[1].sat = 1'b0;
    vecs[2].pat = therm(200); vecs[2].at = 16'd160; vecs[2].fine = 8'd200; vecs[2].sat = 1'b1;
    vecs[3].pat = therm(199); vecs[3].at = 16'd190; vecs[3].fine = 8'd199; vecs[3].sat = 1'b0;
    vecs[4].pat = therm(1);   vecs[4].at = 16'd220; vecs[4].fine = 8'd1;   vecs[4].sat = 1'b0;
    vecs[5].pat = '0;         vecs[5].pat[15:0] = 16'hF0F1;
                              vecs[5].at = 16'd250; vecs[5].fine = 8'd9;   vecs[5].sat = 1'b0;

    // Reset and idle
    rst_n = 1'b0; hit = 1'b0; enable = 1'b1; ts_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs", all_outs(), 64'd0);
    end

    // Table-driven captures with immediate acceptance
    for (int v = 0; v < 6; v++) begin
      wait_coarse(vecs[v].at);
      cur_pat = vecs[v].pat;
      force dut.taps = cur_pat;
      @(negedge clk);
      release dut.taps;
      @(negedge clk);
      check("valid_before_latency", 64'(ts_valid), 64'd0);
      @(negedge clk);
      check("vec_ts", ts_fields(), 64'({1'b1, vecs[v].at, vecs[v].fine, vecs[v].sat}));
      check("vec_busy", 64'(busy), 64'd1);
      @(negedge clk);
      check("vec_valid_drop", 64'(ts_valid), 64'd0);
      repeat (D - 1) @(negedge clk);
      check("vec_dead_busy", 64'(busy), 64'd1);
      @(negedge clk);
      check("vec_idle", 64'(busy), 64'd0);
    end

    // Backpressure with two extra hits
    ts_ready = 1'b0;
    exp_c = tb_coarse;
    pulse_hit();
    @(negedge clk);
    check("bp_capture", ts_fields(), 64'({1'b1, exp_c, 8'd200, 1'b1}));
    for (int i = 0; i < 10; i++) begin
      hit = (i == 1 || i == 5);
      @(negedge clk);
      check("bp_hold", ts_fields(), 64'({1'b1, exp_c, 8'd200, 1'b1}));
    end
    check("bp_miss2", 64'(miss_cnt), 64'd2);
    ts_ready = 1'b1;
    @(negedge clk);
    check("bp_accept", 64'(ts_valid), 64'd0);
    wait_idle();

    // Miss counter saturation: capture then 300 hits while holding
    ts_ready = 1'b0;
    pulse_hit();
    @(negedge clk);
    check("sat_capture", 64'(ts_valid), 64'd1);
    for (int i = 0; i < 252; i++) pulse_hit();
    repeat (3) @(negedge clk);
    check("miss_254", 64'(miss_cnt), 64'd254);
    for (int i = 0; i < 48; i++) pulse_hit();
    repeat (3) @(negedge clk);
    check("miss_255", 64'(miss_cnt), 64'd255);
    check("sat_still_valid", 64'(ts_valid), 64'd1);

    // Abort in HOLD
    enable = 1'b0;
    @(negedge clk);
    check("abort", 64'({ts_valid, miss_cnt, busy}), 64'd0);

    // Hit high while disabled and at enable rise: no capture
    hit = 1'b1;
    repeat (4) @(negedge clk);
    check("dis_hit_ignored", 64'({ts_valid, miss_cnt, busy}), 64'd0);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    check("en_rise_hit_high", 64'({ts_valid, miss_cnt, busy}), 64'd0);
    hit = 1'b0;
    repeat (3) @(negedge clk);
    ts_ready = 1'b1;
    exp_c = tb_coarse;
    pulse_hit();
    @(negedge clk);
    check("rearm_capture", ts_fields(), 64'({1'b1, exp_c, 8'd200, 1'b1}));
    @(negedge clk);
    check("rearm_accept", 64'(ts_valid), 64'd0);
    wait_idle();

    // Async reset while holding a timestamp
    ts_ready = 1'b0;
    pulse_hit();
    @(negedge clk);
    check("pre_reset_valid", 64'(ts_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset", all_outs(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ts_ready = 1'b1;
    @(negedge clk);
    check("post_reset", all_outs(), 64'd0);

    // Coarse wrap: hit sampled at 0xFFFF
    wait_coarse(16'hFFFF);
    pulse_hit();
    @(negedge clk);
    check("wrap_capture", ts_fields(), 64'({1'b1, 16'hFFFF, 8'd200, 1'b1}));
    @(negedge clk);
    check("wrap_accept", 64'(ts_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_carry_chain_channel.md
Name: tdc_carry_chain_channel

Overview:
Single-channel time-to-digital converter front end built on a parametrised CARRY4 tapped delay line. Samples the chain every clock, detects a hit edge, encodes the fine time with a bubble-tolerant ones-count and pairs it with a coarse clock-count timestamp. Each result is held until accepted on a valid/ready output. Instantiated once per TDC input and feeds the readout FIFO/arbiter.

Parameters:
NCARRY4, 50, number of cascaded CARRY4 cells; chain length L = 4*NCARRY4 taps
COARSE_W, 16, coarse counter width
FINE_W, clog2(L+1) (localparam), fine-code width
DEAD_CYCLES, 4, minimum clocks after a capture before re-arm (>=1)
MISS_W, 8, width of the saturating missed-hit counter

Ports:
clk  in  1  sampling/system clock
rst_n  in  1  asynchronous active-low reset
hit  in  1  asynchronous hit; drives chain CYINIT (CI tied 0)
enable  in  1  arms channel; low forces IDLE and clears miss_cnt
ts_valid  out  1  timestamp available
ts_ready  in  1  consumer accepts when ts_valid & ts_ready
ts_coarse  out  COARSE_W  coarse count at sampling edge E0
ts_fine  out  FINE_W  number of '1' taps at E0 (larger = earlier hit)
ts_sat  out  1  fine code == L (hit older than chain length)
miss_cnt  out  MISS_W  hits detected while not IDLE, saturating
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0, FSM IDLE, tap registers 0, coarse counter 0.
- Coarse counter increments every clk, wraps mod 2^COARSE_W. A two-deep delayed copy is kept so the latched value equals the count at E0.
- Pipeline: taps registered at E0 (s1), re-registered at E1 (s2, metastability). prev0 holds the s2 tap[0] of the previous cycle.
- Edge detect at E1: det = s2[0] & ~prev0.
- Fine code = popcount(s2) over all L taps. Ones-count tolerates bubbles, with no first-zero search. Registered at E2 together with ts_coarse; ts_valid rises after E2, i.e. a latency of 2 clocks from E0.
- FSM states:
  - IDLE: det & enable -> CAPTURE.
  - CAPTURE (1 cycle): load ts_* registers, set ts_valid -> HOLD.
  - HOLD: ts_valid & ts_ready -> DEAD. ts_* held stable while ts_valid & ~ts_ready.
  - DEAD: count DEAD_CYCLES clocks, then wait for s2[0]==0 (hit released) -> IDLE.
- ts_valid drops in the cycle after the handshake. No new capture is possible within DEAD_CYCLES+1 clocks of acceptance.
- Miss: det while FSM != IDLE and enable=1 -> miss_cnt+1, saturating at 2^MISS_W-1.
- det in IDLE with enable=0: ignored, not counted.
- enable low mid-operation: the next clock goes to IDLE, ts_valid=0, and a pending timestamp is discarded.
- Async reset mid-operation: immediate return to the reset state; no partial output.
- ts_sat = (popcount == L). The value is still reported.
- Hit already high at enable rise: no det until the hit is observed low then high again.

Decomposition:
- Shared package tdc_pkg:
  - FSM state encoding (IDLE, CAPTURE, HOLD, DEAD)
  - clog2 function
  - FINE_W derivation
  - default NCARRY4/COARSE_W
- Delay line: the team's existing CARRY4 chain module, NCARRY4 passed through, keep attributes on taps.
- One natural sub-module: therm_popcount_enc (L-bit in, FINE_W-bit out).
  - Pipelined adder tree; combinational in this version.
  - A future register stage must add 1 to the stated latency.

Test Plan:
- Reset/idle: rst_n low 3 clk, then high with enable=1 and no hit -> all outputs 0, busy=0 for 20 clk.
- Basic capture: force s1 pattern with 37 ones at coarse=100, ts_ready=1 -> ts_valid for 1 clk with ts_coarse=100, ts_fine=37, ts_sat=0; busy returns 0 after DEAD_CYCLES and hit release.
- Bubble: pattern 1110_1101 followed by zeros -> ts_fine=6.
- Saturation: all L=200 taps '1' on first sample -> ts_fine=200, ts_sat=1.
- Backpressure and miss: ts_ready=0 for 10 clk with 2 more hit edges -> ts_* stable, miss_cnt=2; raise ts_ready -> accepted.
  - Repeat to 300 hits with MISS_W=8 -> miss_cnt=255.
- Abort and wrap: enable low in HOLD -> ts_valid=0 next clk, miss_cnt=0. Hit at coarse=0xFFFF -> ts_coarse=0xFFFF with no off-by-wrap error.
